intdiv_post: RTL and testbench
==============================

# intdiv_post

Post-processing stage of the radix-16 SRT integer divider. It receives the final carry-save remainder and the on-the-fly quotient pair (Q, Q−1) from the last iteration, and resolves them into the final quotient and remainder. It also denormalizes the remainder, applies the operand signs, and substitutes the divide-by-zero result. It sits between the iteration datapath and the divider's result port, with valid/ready handshakes on both sides.

## Interface
Parameters:
- D_W, 32, operand/quotient/remainder width
- REM_W, 1 + D_W + 2 + 3, carry-save remainder width; must match the iteration block

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid_i  in  1  final iteration data valid
- in_ready_o  out  1  block can accept; high only in IDLE
- rem_s_i  in  REM_W  final remainder, sum vector
- rem_c_i  in  REM_W  final remainder, carry vector
- quo_iter_i  in  D_W  on-the-fly quotient Q
- quo_m1_iter_i  in  D_W  on-the-fly quotient Q−1
- D_norm_i  in  D_W  normalized divisor magnitude; MSB = 1
- norm_shift_i  in  $clog2(D_W)  left shift applied during divisor normalization
- quo_neg_i  in  1  negate final quotient
- rem_neg_i  in  1  negate final remainder
- div_zero_i  in  1  divisor was zero
- dividend_i  in  D_W  original dividend, returned as remainder on divide-by-zero
- out_valid_o  out  1  result valid
- out_ready_i  in  1  consumer accepts result
- quo_o  out  D_W  final quotient, two's complement
- rem_o  out  D_W  final remainder, two's complement

## Operation
States: IDLE, CPA, FIX, OUT. The state is held in flops. in_ready_o = (state == IDLE).

- **IDLE**
  - When in_valid_i is high, register all inputs.
  - If div_zero_i = 1, go to OUT with quo_o = all ones and rem_o = dividend_i. Signs are ignored.
  - Otherwise go to CPA.
- **CPA**
  - Compute rem_full = rem_s + rem_c, modulo 2^REM_W.
  - Register R = rem_full[REM_W-1:5] as a (D_W+1)-bit two's complement value. R is aligned with {1'b0, D_norm}.
  - Go to FIX.
- **FIX**
  - If R[D_W] = 1: q = Q−1 and r = R + {1'b0, D_norm}, keeping D_W bits.
  - Otherwise: q = Q and r = R[D_W-1:0].
  - Denormalize: r_d = r >> norm_shift (logical).
  - Apply signs: quo = quo_neg ? −q : q, and rem = rem_neg ? −r_d : r_d. Both are D_W-bit, modulo 2^D_W.
  - Register quo_o and rem_o. Go to OUT.
- **OUT**
  - out_valid_o = 1.
  - If out_ready_i is high, go to IDLE. Otherwise hold.

Width rules:
- After correction, 0 ≤ r < D_norm is guaranteed for legal inputs, so r fits D_W unsigned bits.
- Bits [4:0] of rem_full are ignored.
- Overflow (MIN_INT / −1) is handled upstream. This block gets ordinary operands for it.

## Timing
- Reset values: state = IDLE, out_valid_o = 0, in_ready_o = 1, quo_o = 0, rem_o = 0. All internal registers are cleared.
- Latency from an in_valid_i && in_ready_o edge at cycle t to out_valid_o:
  - Normal path: t+3.
  - div_zero path: t+1.
- out_valid_o stays high, with quo_o and rem_o stable, until an out_ready_i edge is sampled. It drops the cycle after that handshake.
- in_ready_o is low from the accept cycle until the cycle after the output handshake. There is no overlap: in_valid_i during CPA, FIX or OUT is ignored, and the upstream must hold its data.
- Back-to-back throughput is one result per 4 cycles (normal) or 2 cycles (div_zero).
- quo_o and rem_o keep their last values in IDLE. Consumers qualify them with out_valid_o.
- Asserting rst_n low in any state, including mid-operation, returns to IDLE asynchronously and drops out_valid_o immediately. The in-flight operation is discarded and no result is produced.

## Test plan
- **Unsigned 100/7, positive remainder.** D_W = 32, D_norm = 0xE0000000, norm_shift = 29, R = 2<<29 (rem_s = R<<5, rem_c = 0), Q = 14, Q−1 = 13 → at t+3, quo_o = 14 and rem_o = 2.
- **Unsigned 100/7, negative remainder.** R = −5<<29, split across rem_s and rem_c with a nonzero carry vector, Q = 15, Q−1 = 14 → quo_o = 14 and rem_o = 2.
- **Signed −100/7.** Same as the previous case plus quo_neg = rem_neg = 1 → quo_o = 0xFFFFFFF2 and rem_o = 0xFFFFFFFE.
- **Divide by zero.** div_zero = 1, dividend = 0x12345678, quo_neg = 1 → at t+1, quo_o = 0xFFFFFFFF and rem_o = 0x12345678.
- **Backpressure.** out_ready_i held low for 5 cycles in OUT → outputs stable, out_valid_o high, in_ready_o low, and a competing in_valid_i is ignored. Raise out_ready_i → IDLE on the next cycle, and the next accept proceeds.
- **Reset mid-operation.** Pulse rst_n low during FIX → out_valid_o = 0, in_ready_o = 1, quo_o = rem_o = 0, and no stale result appears afterwards.

Source files
------------

// File: rtl/intdiv_post_if.sv
// Handshake and data bundle between the SRT iteration datapath, the
// post-processing stage and the divider result consumer.
interface intdiv_post_if #(
    parameter int D_W   = 32,
    parameter int REM_W = 1 + D_W + 2 + 3
);
    logic                   in_valid_i;
    logic                   in_ready_o;
    logic [REM_W-1:0]       rem_s_i;
    logic [REM_W-1:0]       rem_c_i;
    logic [D_W-1:0]         quo_iter_i;
    logic [D_W-1:0]         quo_m1_iter_i;
    logic [D_W-1:0]         D_norm_i;
    logic [$clog2(D_W)-1:0] norm_shift_i;
    logic                   quo_neg_i;
    logic                   rem_neg_i;
    logic                   div_zero_i;
    logic [D_W-1:0]         dividend_i;
    logic                   out_valid_o;
    logic                   out_ready_i;
    logic [D_W-1:0]         quo_o;
    logic [D_W-1:0]         rem_o;

    modport slave (
        input  in_valid_i, rem_s_i, rem_c_i, quo_iter_i, quo_m1_iter_i, D_norm_i,
               norm_shift_i, quo_neg_i, rem_neg_i, div_zero_i, dividend_i, out_ready_i,
        output in_ready_o, out_valid_o, quo_o, rem_o
    );

    modport master (
        output in_valid_i, rem_s_i, rem_c_i, quo_iter_i, quo_m1_iter_i, D_norm_i,
               norm_shift_i, quo_neg_i, rem_neg_i, div_zero_i, dividend_i, out_ready_i,
        input  in_ready_o, out_valid_o, quo_o, rem_o
    );
endinterface

// File: rtl/intdiv_post.sv
// SRT divider post-processing: resolves carry-save remainder and Q/Q-1 into
// the final signed quotient/remainder, with divide-by-zero substitution.
module intdiv_post #(
    parameter int D_W   = 32,
    parameter int REM_W = 1 + D_W + 2 + 3
) (
    input  logic          clk,
    input  logic          rst_n,
    intdiv_post_if.slave  bus
);
    localparam int SH_W = $clog2(D_W);

    typedef enum logic [1:0] {S_IDLE, S_CPA, S_FIX, S_OUT} state_t;

    state_t           r_state, w_state_nx;
    logic [REM_W-1:0] r_rem_s, r_rem_c;
    logic [D_W-1:0]   r_q, r_qm1, r_dnorm;
    logic [SH_W-1:0]  r_shift;
    logic             r_qneg, r_rneg;
    logic [D_W:0]     r_R;
    logic [D_W-1:0]   r_quo, r_rem;

    logic             w_accept;
    logic [D_W:0]     w_R;
    logic [D_W-1:0]   w_r, w_rd, w_q, w_quo, w_rem;

    assign w_accept        = (r_state == S_IDLE) && bus.in_valid_i;
    assign bus.in_ready_o  = (r_state == S_IDLE);
    assign bus.out_valid_o = (r_state == S_OUT);
    assign bus.quo_o       = r_quo;
    assign bus.rem_o       = r_rem;

    // Low 5 bits of the resolved remainder are guard bits below the divisor alignment.
    assign w_R   = (D_W+1)'((r_rem_s + r_rem_c) >> 5);

    // A negative partial remainder means the last digit overshot by one.
    assign w_q   = r_R[D_W] ? r_qm1 : r_q;
    assign w_r   = r_R[D_W] ? (r_R[D_W-1:0] + r_dnorm) : r_R[D_W-1:0];
    assign w_rd  = w_r >> r_shift;
    assign w_quo = r_qneg ? -w_q  : w_q;
    assign w_rem = r_rneg ? -w_rd : w_rd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE:  if (bus.in_valid_i) w_state_nx = bus.div_zero_i ? S_OUT : S_CPA;
            S_CPA:   w_state_nx = S_FIX;
            S_FIX:   w_state_nx = S_OUT;
            S_OUT:   if (bus.out_ready_i) w_state_nx = S_IDLE;
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rem_s <= '0;
            r_rem_c <= '0;
            r_q     <= '0;
            r_qm1   <= '0;
            r_dnorm <= '0;
            r_shift <= '0;
            r_qneg  <= 1'b0;
            r_rneg  <= 1'b0;
            r_R     <= '0;
            r_quo   <= '0;
            r_rem   <= '0;
        end else begin
            if (w_accept) begin
                r_rem_s <= bus.rem_s_i;
                r_rem_c <= bus.rem_c_i;
                r_q     <= bus.quo_iter_i;
                r_qm1   <= bus.quo_m1_iter_i;
                r_dnorm <= bus.D_norm_i;
                r_shift <= bus.norm_shift_i;
                r_qneg  <= bus.quo_neg_i;
                r_rneg  <= bus.rem_neg_i;
                if (bus.div_zero_i) begin
                    r_quo <= '1;
                    r_rem <= bus.dividend_i;
                end
            end
            if (r_state == S_CPA) r_R <= w_R;
            if (r_state == S_FIX) begin
                r_quo <= w_quo;
                r_rem <= w_rem;
            end
        end
    end
endmodule

// File: tb/tb_intdiv_post.sv
// Randomized scoreboard bench for intdiv_post: stimulus derived from true
// integer division, checked by an independent output monitor.
module tb_intdiv_post;
    localparam int D_W   = 32;
    localparam int REM_W = 38;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    intdiv_post_if #(.D_W(D_W), .REM_W(REM_W)) bus();
    intdiv_post #(.D_W(D_W), .REM_W(REM_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        logic [D_W-1:0] q;
        logic [D_W-1:0] r;
        int             acc;
        int             lat;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   ncyc  = 0;
    bit   bp_hold = 1'b0;

    always @(posedge clk) ncyc <= ncyc + 1;

    task automatic check(input string nm, input logic [D_W-1:0] act, input logic [D_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic checki(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Monitor: latency on the first valid cycle, data on each handshake.
    initial begin
        bit   seen;
        exp_t e;
        seen = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) seen = 1'b0;
            else if (bus.out_valid_o) begin
                if (!seen) begin
                    checki("outstanding", int'(sb.size() > 0), 1);
                    if (sb.size() > 0) checki("latency", ncyc - sb[0].acc, sb[0].lat);
                end
                if (bus.out_ready_i && sb.size() > 0) begin
                    e = sb.pop_front();
                    check("quo", bus.quo_o, e.q);
                    check("rem", bus.rem_o, e.r);
                end
                seen = !bus.out_ready_i;
            end else seen = 1'b0;
        end
    end

    // Random consumer backpressure, changed just after the rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!bp_hold) bus.out_ready_i = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic send(input logic [REM_W-1:0] rs, input logic [REM_W-1:0] rc,
                        input logic [D_W-1:0] q, input logic [D_W-1:0] qm1,
                        input logic [D_W-1:0] dn, input logic [4:0] sh,
                        input logic qn, input logic rn, input logic dz,
                        input logic [D_W-1:0] dvd,
                        input logic [D_W-1:0] eq, input logic [D_W-1:0] er);
        exp_t e;
        int   t;
        t = 0;
        @(negedge clk);
        while (!bus.in_ready_o && t < 50) begin
            @(negedge clk);
            t++;
        end
        checki("in_ready_wait", int'(bus.in_ready_o), 1);
        bus.rem_s_i = rs; bus.rem_c_i = rc;
        bus.quo_iter_i = q; bus.quo_m1_iter_i = qm1;
        bus.D_norm_i = dn; bus.norm_shift_i = sh;
        bus.quo_neg_i = qn; bus.rem_neg_i = rn;
        bus.div_zero_i = dz; bus.dividend_i = dvd;
        bus.in_valid_i = 1'b1;
        e.q = eq; e.r = er; e.acc = ncyc; e.lat = dz ? 1 : 3;
        sb.push_back(e);
        @(negedge clk);
        // Scramble the held inputs so a late capture shows up as wrong data.
        bus.in_valid_i = 1'b0;
        bus.rem_s_i = {$urandom, $urandom};
        bus.quo_iter_i = $urandom;
        bus.quo_m1_iter_i = $urandom;
        bus.div_zero_i = 1'b0;
        bus.dividend_i = $urandom;
    endtask

    // Build iteration outputs from a true division, choosing randomly whether
    // the last iteration left a negative remainder.
    task automatic rand_op();
        logic [D_W-1:0] a, b, ma, mb, qv, rv, dn, qi;
        logic [63:0]    full, tmp;
        logic [REM_W-1:0] rf, rc;
        longint R;
        bit sg, neg;
        logic qn, rn;
        int s;
        a = $urandom;
        case ($urandom_range(0, 3))
            0: b = $urandom;
            1: b = $urandom_range(1, 255);
            2: b = 32'd1 << $urandom_range(0, 31);
            default: b = $urandom_range(1, 65535);
        endcase
        tmp = {$urandom, $urandom};
        if ($urandom_range(0, 9) == 0) begin
            send(tmp[REM_W-1:0], ~tmp[REM_W-1:0], $urandom, $urandom, $urandom, 5'($urandom),
                 1'($urandom), 1'($urandom), 1'b1, a, '1, a);
            return;
        end
        if (b == 0) b = 1;
        sg = 1'($urandom);
        if (sg && a == 32'h80000000 && b == 32'hFFFFFFFF) b = 32'd7;
        ma = (sg && a[31]) ? -a : a;
        mb = (sg && b[31]) ? -b : b;
        qv = ma / mb;
        rv = ma % mb;
        dn = mb; s = 0;
        while (!dn[31]) begin
            dn = dn << 1;
            s++;
        end
        qn = sg && (a[31] ^ b[31]);
        rn = sg && a[31];
        neg = 1'($urandom);
        R = longint'({32'b0, rv}) << s;
        if (neg) R = R - longint'({32'b0, dn});
        full = 64'(R <<< 5) | 64'($urandom_range(0, 31));
        rf = full[REM_W-1:0];
        rc = tmp[REM_W-1:0];
        qi = neg ? qv + 1 : qv;
        send(rf - rc, rc, qi, qi - 1, dn, 5'(s), qn, rn, 1'b0, $urandom,
             qn ? -qv : qv, rn ? -rv : rv);
    endtask

    initial begin
        logic [REM_W-1:0] rneg, rc0;
        int t;
        bus.in_valid_i = 0; bus.rem_s_i = '0; bus.rem_c_i = '0;
        bus.quo_iter_i = '0; bus.quo_m1_iter_i = '0; bus.D_norm_i = '0;
        bus.norm_shift_i = '0; bus.quo_neg_i = 0; bus.rem_neg_i = 0;
        bus.div_zero_i = 0; bus.dividend_i = '0; bus.out_ready_i = 0;

        #1;
        checki("rst_out_valid", int'(bus.out_valid_o), 0);
        checki("rst_in_ready", int'(bus.in_ready_o), 1);
        check("rst_quo", bus.quo_o, '0);
        check("rst_rem", bus.rem_o, '0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed: 100/7 with positive and negative final remainder, signed, div0.
        rc0  = 38'h1_2345_6789;
        rneg = (38'h3F_FFFF_FFFF - 38'd5 + 38'd1) << 34;
        send(38'd2 << 34, '0, 32'd14, 32'd13, 32'hE0000000, 5'd29, 0, 0, 0, '0, 32'd14, 32'd2);
        send(rneg - rc0, rc0, 32'd15, 32'd14, 32'hE0000000, 5'd29, 0, 0, 0, '0, 32'd14, 32'd2);
        send(rneg - rc0, rc0, 32'd15, 32'd14, 32'hE0000000, 5'd29, 1, 1, 0, '0,
             32'hFFFFFFF2, 32'hFFFFFFFE);
        send('0, '0, 32'd3, 32'd2, 32'h80000000, 5'd0, 1, 0, 1, 32'h12345678,
             32'hFFFFFFFF, 32'h12345678);

        // Backpressure: hold out_ready low five cycles with a competing request.
        @(posedge clk); #1;
        bp_hold = 1'b1;
        bus.out_ready_i = 1'b0;
        send(38'd2 << 34, '0, 32'd14, 32'd13, 32'hE0000000, 5'd29, 0, 0, 0, '0, 32'd14, 32'd2);
        t = 0;
        while (!bus.out_valid_o && t < 20) begin
            @(negedge clk);
            t++;
        end
        for (int i = 0; i < 5; i++) begin
            checki("bp_valid", int'(bus.out_valid_o), 1);
            checki("bp_in_ready", int'(bus.in_ready_o), 0);
            check("bp_quo", bus.quo_o, 32'd14);
            check("bp_rem", bus.rem_o, 32'd2);
            bus.div_zero_i = 1'b1;
            bus.dividend_i = 32'hDEADBEEF;
            bus.in_valid_i = 1'b1;
            @(negedge clk);
        end
        @(posedge clk); #1;
        bus.in_valid_i = 1'b0;
        bus.div_zero_i = 1'b0;
        bus.out_ready_i = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checki("bp_release_in_ready", int'(bus.in_ready_o), 1);
        checki("bp_release_valid", int'(bus.out_valid_o), 0);
        bp_hold = 1'b0;
        send(38'd2 << 34, '0, 32'd14, 32'd13, 32'hE0000000, 5'd29, 1, 1, 0, '0,
             32'hFFFFFFF2, 32'hFFFFFFFE);

        // Reset while in FIX: the in-flight result must vanish.
        send(38'd2 << 34, '0, 32'd14, 32'd13, 32'hE0000000, 5'd29, 0, 0, 0, '0, 32'd14, 32'd2);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        checki("midrst_valid", int'(bus.out_valid_o), 0);
        checki("midrst_in_ready", int'(bus.in_ready_o), 1);
        check("midrst_quo", bus.quo_o, '0);
        check("midrst_rem", bus.rem_o, '0);
        void'(sb.pop_back());
        #1 rst_n = 1'b1;
        repeat (8) @(negedge clk);
        checki("midrst_no_stale", int'(bus.out_valid_o), 0);

        for (int i = 0; i < 150; i++) rand_op();

        t = 0;
        while (sb.size() > 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        checki("drain", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
